// File: rtl/siu_niu_out_sched.sv
// SIU->NIU outbound scheduler: round-robin between read responses (header + 4 beats)
// and write acks (header only), with per-lane parity and NIU packet-credit tracking.
module siu_niu_out_sched #(
    parameter int CREDITS = 8,
    parameter int CW      = 4,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic          iol2clk,
    input  logic          rst_l,
    input  logic          rdr_req,
    input  logic [127:0]  rdr_hdr,
    output logic          rdr_gnt,
    input  logic [127:0]  rdr_data,
    output logic          rdr_data_rd,
    input  logic          wra_req,
    input  logic [127:0]  wra_hdr,
    output logic          wra_gnt,
    input  logic          niu_sio_credit,
    output logic          sio_niu_hdr_vld,
    output logic          sio_niu_datareq,
    output logic [127:0]  sio_niu_data,
    output logic [7:0]    sio_niu_parity,
    output logic [CW-1:0] credit_cnt,
    output logic          err_credit_ovf
);

    typedef enum logic {ST_IDLE, ST_PAY} state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    state_t          state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic            pref_rdr_q, pref_rdr_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic            err_q, err_d;
    logic            hdr_vld_q, hdr_vld_d;
    logic            datareq_q, datareq_d;
    logic [127:0]    data_q, data_d;
    logic [7:0]      parity_q, parity_d;
    logic [7:0]      lane_par;
    logic            drive;
    logic            rdr_elig, wra_elig, rdr_win, wra_win, grant;

    // Lane parity is taken from the value about to be registered.
    for (genvar gi = 0; gi < 8; gi++) begin : g_par
        assign lane_par[gi] = (^data_d[16*gi +: 16]) ^ PAR_ODD;
    end

    assign parity_d = drive ? lane_par : 8'h00;

    always_comb begin
        rdr_elig = (state_q == ST_IDLE) && rdr_req && (credit_q != '0);
        wra_elig = (state_q == ST_IDLE) && wra_req && (credit_q != '0);
        rdr_win  = rdr_elig && (!wra_elig || pref_rdr_q);
        wra_win  = wra_elig && !rdr_win;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        pref_rdr_d  = pref_rdr_q;
        hdr_vld_d   = 1'b0;
        datareq_d   = 1'b0;
        data_d      = '0;
        drive       = 1'b0;
        rdr_gnt     = 1'b0;
        wra_gnt     = 1'b0;
        rdr_data_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rdr_win) begin
                    rdr_gnt    = 1'b1;
                    hdr_vld_d  = 1'b1;
                    datareq_d  = 1'b1;
                    data_d     = rdr_hdr;
                    drive      = 1'b1;
                    state_d    = ST_PAY;
                    beat_d     = 2'd0;
                    pref_rdr_d = 1'b0;
                end else if (wra_win) begin
                    wra_gnt    = 1'b1;
                    hdr_vld_d  = 1'b1;
                    data_d     = wra_hdr;
                    drive      = 1'b1;
                    pref_rdr_d = 1'b1;
                end
            end
            ST_PAY: begin
                rdr_data_rd = 1'b1;
                data_d      = rdr_data;
                drive       = 1'b1;
                beat_d      = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A grant and a returned credit in the same cycle cancel out.
    always_comb begin
        grant    = rdr_gnt | wra_gnt;
        credit_d = credit_q;
        err_d    = err_q;
        if (grant && !niu_sio_credit) begin
            credit_d = credit_q - CRED_ONE;
        end else if (!grant && niu_sio_credit) begin
            if (credit_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CRED_ONE;
            end
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            beat_q     <= 2'd0;
            pref_rdr_q <= 1'b1;
            credit_q   <= CRED_MAX;
            err_q      <= 1'b0;
            hdr_vld_q  <= 1'b0;
            datareq_q  <= 1'b0;
            data_q     <= '0;
            parity_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            pref_rdr_q <= pref_rdr_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
            hdr_vld_q  <= hdr_vld_d;
            datareq_q  <= datareq_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
        end
    end

    assign sio_niu_hdr_vld = hdr_vld_q;
    assign sio_niu_datareq = datareq_q;
    assign sio_niu_data    = data_q;
    assign sio_niu_parity  = parity_q;
    assign credit_cnt      = credit_q;
    assign err_credit_ovf  = err_q;

endmodule

// File: tb/tb_siu_niu_out_sched.sv
// Bench for siu_niu_out_sched: default instance (8 credits, even parity) plus a
// 2-credit odd-parity instance sharing the same stimulus.
module tb_siu_niu_out_sched;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         rdr_req, wra_req, credit;
    logic [127:0] rdr_hdr, wra_hdr, rdr_data;

    logic         rg0, rd0, wg0, hv0, dr0, err0;
    logic [127:0] data0;
    logic [7:0]   par0;
    logic [3:0]   cnt0;
    logic         rg1, rd1, wg1, hv1, dr1, err1;
    logic [127:0] data1;
    logic [7:0]   par1;
    logic [3:0]   cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    siu_niu_out_sched dut0 (
        .iol2clk(clk), .rst_l(rst_l),
        .rdr_req(rdr_req), .rdr_hdr(rdr_hdr), .rdr_gnt(rg0),
        .rdr_data(rdr_data), .rdr_data_rd(rd0),
        .wra_req(wra_req), .wra_hdr(wra_hdr), .wra_gnt(wg0),
        .niu_sio_credit(credit),
        .sio_niu_hdr_vld(hv0), .sio_niu_datareq(dr0), .sio_niu_data(data0),
        .sio_niu_parity(par0), .credit_cnt(cnt0), .err_credit_ovf(err0)
    );

    siu_niu_out_sched #(.CREDITS(2), .CW(4), .PAR_ODD(1'b1)) dut1 (
        .iol2clk(clk), .rst_l(rst_l),
        .rdr_req(rdr_req), .rdr_hdr(rdr_hdr), .rdr_gnt(rg1),
        .rdr_data(rdr_data), .rdr_data_rd(rd1),
        .wra_req(wra_req), .wra_hdr(wra_hdr), .wra_gnt(wg1),
        .niu_sio_credit(credit),
        .sio_niu_hdr_vld(hv1), .sio_niu_datareq(dr1), .sio_niu_data(data1),
        .sio_niu_parity(par1), .credit_cnt(cnt1), .err_credit_ovf(err1)
    );

    typedef struct packed {
        logic       r, w, c, rg, wg;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic         hv, dr, drv;
        logic [127:0] data;
        int           idx;
    } exp_t;

    vec_t tbl [30];
    exp_t sb [$];
    int   beat_cnt;
    int   m_beat;
    int   m_left;

    function automatic vec_t mk(int r, int w, int c, int rg, int wg, int cnt);
        vec_t v;
        v.r   = (r != 0);
        v.w   = (w != 0);
        v.c   = (c != 0);
        v.rg  = (rg != 0);
        v.wg  = (wg != 0);
        v.cnt = 4'(cnt);
        return v;
    endfunction

    function automatic logic [7:0] par(logic [127:0] d, logic odd);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = (^d[16*i +: 16]) ^ odd;
        end
        return p;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        rdr_req  = 1'b0;
        wra_req  = 1'b0;
        credit   = 1'b0;
        rdr_hdr  = '0;
        wra_hdr  = '0;
        rdr_data = '0;
    endtask

    task automatic reset_checks();
        chk("rst hdr_vld", 128'(hv0), 128'(0));
        chk("rst datareq", 128'(dr0), 128'(0));
        chk("rst data", data0, 128'(0));
        chk("rst parity", 128'(par0), 128'(0));
        chk("rst parity odd", 128'(par1), 128'(0));
        chk("rst credit_cnt", 128'(cnt0), 128'(8));
        chk("rst credit_cnt c2", 128'(cnt1), 128'(2));
        chk("rst err", 128'(err0), 128'(0));
        chk("rst rdr_data_rd", 128'(rd0), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_l = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_l = 1'b1;
        sb.delete();
        beat_cnt = 0;
        m_beat   = 0;
        m_left   = 0;
    endtask

    task automatic sb_check();
        exp_t e;
        logic [7:0] ep;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ep = e.drv ? par(e.data, 1'b0) : 8'h00;
            chk($sformatf("out%0d hdr_vld", e.idx), 128'(hv0), 128'(e.hv));
            chk($sformatf("out%0d datareq", e.idx), 128'(dr0), 128'(e.dr));
            chk($sformatf("out%0d data", e.idx), data0, e.data);
            chk($sformatf("out%0d parity", e.idx), 128'(par0), 128'(ep));
            if (e.idx <= 5) begin
                ep = e.drv ? par(e.data, 1'b1) : 8'h00;
                chk($sformatf("out%0d data odd", e.idx), data1, e.data);
                chk($sformatf("out%0d parity odd", e.idx), 128'(par1), 128'(ep));
            end
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic [3:0] b_cnt [10];
        logic       b_ret [10];
        logic       b_gnt [10];
        logic       prev_g;

        drive_idle();
        rst_l    = 1'b0;
        beat_cnt = 0;
        m_beat   = 0;
        m_left   = 0;

        //                 r  w  c rg wg cnt
        tbl[0]  = mk(1, 0, 0, 1, 0, 8);
        tbl[1]  = mk(0, 0, 0, 0, 0, 7);
        tbl[2]  = mk(0, 0, 0, 0, 0, 7);
        tbl[3]  = mk(0, 0, 0, 0, 0, 7);
        tbl[4]  = mk(0, 0, 0, 0, 0, 7);
        tbl[5]  = mk(0, 1, 0, 0, 1, 7);
        tbl[6]  = mk(0, 1, 0, 0, 1, 6);
        tbl[7]  = mk(0, 1, 0, 0, 1, 5);
        tbl[8]  = mk(0, 0, 1, 0, 0, 4);
        tbl[9]  = mk(0, 0, 1, 0, 0, 5);
        tbl[10] = mk(0, 0, 1, 0, 0, 6);
        tbl[11] = mk(1, 1, 0, 1, 0, 7);
        tbl[12] = mk(1, 1, 0, 0, 0, 6);
        tbl[13] = mk(1, 1, 0, 0, 0, 6);
        tbl[14] = mk(1, 1, 0, 0, 0, 6);
        tbl[15] = mk(1, 1, 0, 0, 0, 6);
        tbl[16] = mk(1, 1, 0, 0, 1, 6);
        tbl[17] = mk(1, 1, 0, 1, 0, 5);
        tbl[18] = mk(1, 1, 1, 0, 0, 4);
        tbl[19] = mk(1, 1, 0, 0, 0, 5);
        tbl[20] = mk(1, 1, 0, 0, 0, 5);
        tbl[21] = mk(1, 1, 0, 0, 0, 5);
        tbl[22] = mk(1, 1, 1, 0, 1, 5);
        tbl[23] = mk(0, 0, 0, 0, 0, 5);
        tbl[24] = mk(1, 0, 0, 1, 0, 5);
        tbl[25] = mk(0, 1, 0, 0, 0, 4);
        tbl[26] = mk(0, 0, 0, 0, 0, 4);
        tbl[27] = mk(0, 0, 0, 0, 0, 4);
        tbl[28] = mk(0, 0, 0, 0, 0, 4);
        tbl[29] = mk(0, 0, 0, 0, 0, 4);

        #12;
        reset_checks();
        @(negedge clk);
        rst_l = 1'b1;

        // Table phase: grants/credits from the table, output stream via scoreboard.
        for (int i = 0; i < 30; i++) begin
            v = tbl[i];
            @(negedge clk);
            sb_check();
            rdr_req  = v.r;
            wra_req  = v.w;
            credit   = v.c;
            rdr_hdr  = {16'hA5A5, 80'h0, 32'(i)};
            wra_hdr  = {16'h5A5A, 80'h0, 32'(i)};
            rdr_data = 128'(beat_cnt + 1);
            #1;
            chk($sformatf("row%0d rdr_gnt", i), 128'(rg0), 128'(v.rg));
            chk($sformatf("row%0d wra_gnt", i), 128'(wg0), 128'(v.wg));
            chk($sformatf("row%0d credit_cnt", i), 128'(cnt0), 128'(v.cnt));
            chk($sformatf("row%0d rdr_data_rd", i), 128'(rd0), 128'(m_left > 0));
            if (rd0) beat_cnt++;
            e.idx = i;
            if (m_left > 0) begin
                e.hv = 1'b0; e.dr = 1'b0; e.drv = 1'b1; e.data = 128'(m_beat + 1);
                m_beat++;
                m_left--;
            end else if (v.rg) begin
                e.hv = 1'b1; e.dr = 1'b1; e.drv = 1'b1; e.data = rdr_hdr;
                m_left = 4;
            end else if (v.wg) begin
                e.hv = 1'b1; e.dr = 1'b0; e.drv = 1'b1; e.data = wra_hdr;
            end else begin
                e.hv = 1'b0; e.dr = 1'b0; e.drv = 1'b0; e.data = '0;
            end
            sb.push_back(e);
        end
        @(negedge clk);
        sb_check();
        drive_idle();

        // Credit exhaustion on the 2-credit instance, single return, grant+return.
        do_reset();
        b_cnt = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
        b_ret = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        b_gnt = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        prev_g = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("cred%0d hdr_vld", k), 128'(hv1), 128'(prev_g));
            wra_req = (k < 9);
            wra_hdr = {16'h1234, 80'h0, 32'(k)};
            credit  = b_ret[k];
            #1;
            chk($sformatf("cred%0d credit_cnt", k), 128'(cnt1), 128'(b_cnt[k]));
            chk($sformatf("cred%0d wra_gnt", k), 128'(wg1), 128'(b_gnt[k]));
            prev_g = b_gnt[k];
        end
        chk("cred no ovf", 128'(err1), 128'(0));
        drive_idle();

        // Credit return at full count sets the sticky overflow flag.
        do_reset();
        @(negedge clk);
        credit = 1'b1;
        @(negedge clk);
        credit = 1'b0;
        #1;
        chk("ovf err", 128'(err0), 128'(1));
        chk("ovf credit_cnt", 128'(cnt0), 128'(8));
        chk("ovf err c2", 128'(err1), 128'(1));
        @(negedge clk);
        chk("ovf sticky", 128'(err0), 128'(1));

        // Reset asserted while payload beat 2 is on the bus.
        do_reset();
        @(negedge clk);
        rdr_req = 1'b1;
        rdr_hdr = {16'hA5A5, 112'h77};
        #1;
        chk("mid gnt", 128'(rg0), 128'(1));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rdr_req  = 1'b0;
            rdr_data = 128'(k);
        end
        chk("mid beat2 data", data0, 128'(2));
        #2;
        rst_l = 1'b0;
        #1;
        chk("mid rst data", data0, 128'(0));
        chk("mid rst parity", 128'(par0), 128'(0));
        chk("mid rst credit_cnt", 128'(cnt0), 128'(8));
        chk("mid rst rdr_data_rd", 128'(rd0), 128'(0));
        @(negedge clk);
        rst_l   = 1'b1;
        rdr_req = 1'b1;
        rdr_hdr = {16'hA5A5, 112'h99};
        #1;
        chk("post rst gnt", 128'(rg0), 128'(1));
        @(negedge clk);
        rdr_req = 1'b0;
        chk("post rst hdr_vld", 128'(hv0), 128'(1));
        chk("post rst datareq", 128'(dr0), 128'(1));
        chk("post rst data", data0, {16'hA5A5, 112'h99});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
